kei_i2c_slave_responder: RTL and testbench

- Synthesizable I2C target (slave) that responds to the DW_apb_i2c master on the shared open-drain SCL/SDA bus.
- Oversamples SCL/SDA on the system clock. Detects START/STOP and decodes a 7-bit address plus R/W bit.
- Writes from the master go into an internal RX FIFO. Reads are served from a byte-wide valid/ready TX port.
- Serves as the bus-side counterpart for I2C bring-up and as a reusable on-chip target.

---
 rtl/kei_i2c_slv_pkg.sv | 17 +
 rtl/kei_i2c_slave_responder_if.sv | 10 +
 rtl/kei_i2c_slv_rx_fifo.sv | 44 ++++
 rtl/kei_i2c_slave_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_kei_i2c_slave_responder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kei_i2c_slv_pkg.sv
// Shared types and constants for the I2C target responder.
package kei_i2c_slv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } slv_state_e;

    localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

endpackage

// File: rtl/kei_i2c_slave_responder_if.sv
// Open-drain I2C bus view: sampled line levels in, pull-down enables out.
interface kei_i2c_slave_responder_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;
    logic scl_oe;

    modport slave  (input scl_i, sda_i, output sda_oe, scl_oe);
    modport master (output scl_i, sda_i, input sda_oe, scl_oe);
endinterface

// File: rtl/kei_i2c_slv_rx_fifo.sv
// Show-ahead synchronous FIFO holding bytes written by the bus master.
module kei_i2c_slv_rx_fifo #(
    parameter int RX_DEPTH = 4,
    parameter int RX_AW    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    logic [7:0]   mem [RX_DEPTH];
    logic [RX_AW:0] wr_ptr_reg;
    logic [RX_AW:0] rd_ptr_reg;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[RX_AW] != rd_ptr_reg[RX_AW]) &&
                     (wr_ptr_reg[RX_AW-1:0] == rd_ptr_reg[RX_AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push on full needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (RX_AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (RX_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[RX_AW-1:0]] <= push_data;
    end

    assign head = empty ? 8'h00 : mem[rd_ptr_reg[RX_AW-1:0]];

endmodule

// File: rtl/kei_i2c_slave_responder.sv
// I2C target: oversampled START/STOP/address decode, RX FIFO for writes, TX port for reads.
// Optional KEI_I2C_SLV_STRETCH_EN: stretch SCL while TX data is missing instead of sending 0xFF.
module kei_i2c_slave_responder
    import kei_i2c_slv_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RX_DEPTH    = 4,
    parameter int RX_AW       = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    kei_i2c_slave_responder_if.slave    bus,
    input  logic [6:0]                  slv_addr,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        addressed,
    output logic                        rd_mode,
    output logic                        stop_det,
    output logic                        rx_nack,
    output logic                        tx_underflow
);
    logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
    logic       scl_d_reg, sda_d_reg;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_hit, stop_hit;
    slv_state_e state_reg;
    logic [3:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [6:0] own_addr_reg;
    logic       sda_oe_reg, addressed_reg, rd_mode_reg, push_reg;
    logic       stop_det_reg, rx_nack_reg, tx_ready_reg, tx_underflow_reg;
    logic       fifo_empty, fifo_full;
`ifdef KEI_I2C_SLV_STRETCH_EN
    logic       scl_oe_reg, stretch_reg;
`endif

    // Lines idle high, so synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_d_reg    <= 1'b1;
            sda_d_reg    <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], bus.sda_i};
            scl_d_reg    <= scl_s;
            sda_d_reg    <= sda_s;
        end
    end

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d_reg;
    assign scl_fall  = ~scl_s & scl_d_reg;
    assign start_hit = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
    assign stop_hit  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= 4'd0;
            shift_reg        <= 8'h00;
            own_addr_reg     <= 7'h00;
            sda_oe_reg       <= 1'b0;
            addressed_reg    <= 1'b0;
            rd_mode_reg      <= 1'b0;
            push_reg         <= 1'b0;
            stop_det_reg     <= 1'b0;
            rx_nack_reg      <= 1'b0;
            tx_ready_reg     <= 1'b0;
            tx_underflow_reg <= 1'b0;
`ifdef KEI_I2C_SLV_STRETCH_EN
            scl_oe_reg       <= 1'b0;
            stretch_reg      <= 1'b0;
`endif
        end else begin
            push_reg         <= 1'b0;
            stop_det_reg     <= 1'b0;
            rx_nack_reg      <= 1'b0;
            tx_ready_reg     <= 1'b0;
            tx_underflow_reg <= 1'b0;
            if (stop_hit || start_hit) begin
                state_reg     <= stop_hit ? IDLE : ADDR;
                stop_det_reg  <= stop_hit;
                bit_cnt_reg   <= 4'd0;
                sda_oe_reg    <= 1'b0;
                addressed_reg <= 1'b0;
                rd_mode_reg   <= 1'b0;
                own_addr_reg  <= slv_addr;
`ifdef KEI_I2C_SLV_STRETCH_EN
                scl_oe_reg    <= 1'b0;
                stretch_reg   <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    ADDR, WR_BYTE: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_s};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                            bit_cnt_reg <= 4'd0;
                            if (state_reg == ADDR) begin
                                if (shift_reg[7:1] == own_addr_reg && own_addr_reg != GEN_CALL_ADDR) begin
                                    state_reg     <= ADDR_ACK;
                                    sda_oe_reg    <= 1'b1;
                                    addressed_reg <= 1'b1;
                                    rd_mode_reg   <= shift_reg[0];
                                end else begin
                                    state_reg <= WAIT_STOP;
                                end
                            end else if (!fifo_full) begin
                                state_reg  <= WR_ACK;
                                push_reg   <= 1'b1;
                                sda_oe_reg <= 1'b1;
                            end else begin
                                state_reg   <= WAIT_STOP;
                                rx_nack_reg <= 1'b1;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            state_reg   <= WR_BYTE;
                            sda_oe_reg  <= 1'b0;
                            bit_cnt_reg <= 4'd0;
                        end
                    end
                    ADDR_ACK, RD_ACK: begin
                        if (state_reg == RD_ACK && scl_rise && sda_s) begin
                            state_reg <= WAIT_STOP;
                        end else if (scl_fall) begin
                            bit_cnt_reg <= 4'd0;
                            if (state_reg == ADDR_ACK && !rd_mode_reg) begin
                                state_reg  <= WR_BYTE;
                                sda_oe_reg <= 1'b0;
                            end else begin
                                // TX fetch at the SCL fall that closes an ACK bit.
                                state_reg <= RD_BYTE;
                                if (tx_valid) begin
                                    shift_reg    <= tx_data;
                                    tx_ready_reg <= 1'b1;
                                    sda_oe_reg   <= ~tx_data[7];
                                end else begin
                                    sda_oe_reg <= 1'b0;
`ifdef KEI_I2C_SLV_STRETCH_EN
                                    scl_oe_reg  <= 1'b1;
                                    stretch_reg <= 1'b1;
`else
                                    shift_reg        <= 8'hFF;
                                    tx_underflow_reg <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                    RD_BYTE: begin
`ifdef KEI_I2C_SLV_STRETCH_EN
                        // SCL stays low one cycle past the load so bit 7 sets up first.
                        if (stretch_reg) begin
                            if (tx_valid) begin
                                shift_reg    <= tx_data;
                                tx_ready_reg <= 1'b1;
                                sda_oe_reg   <= ~tx_data[7];
                                stretch_reg  <= 1'b0;
                            end
                        end else if (scl_oe_reg) begin
                            scl_oe_reg <= 1'b0;
                        end
`endif
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                state_reg   <= RD_ACK;
                                sda_oe_reg  <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                            end else begin
                                shift_reg  <= {shift_reg[6:0], 1'b0};
                                sda_oe_reg <= ~shift_reg[6];
                            end
                        end
                    end
                    default: sda_oe_reg <= 1'b0;
                endcase
            end
        end
    end

    kei_i2c_slv_rx_fifo #(
        .RX_DEPTH (RX_DEPTH),
        .RX_AW    (RX_AW)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_reg),
        .push_data (shift_reg),
        .pop       (rx_ready),
        .head      (rx_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.sda_oe   = sda_oe_reg;
`ifdef KEI_I2C_SLV_STRETCH_EN
    assign bus.scl_oe   = scl_oe_reg;
`else
    assign bus.scl_oe   = 1'b0;
`endif
    assign rx_valid     = ~fifo_empty;
    assign tx_ready     = tx_ready_reg;
    assign addressed    = addressed_reg;
    assign rd_mode      = rd_mode_reg;
    assign stop_det     = stop_det_reg;
    assign rx_nack      = rx_nack_reg;
    assign tx_underflow = tx_underflow_reg;

endmodule

// File: tb/tb_kei_i2c_slave_responder.sv
// Directed bench: a bit-banged I2C master drives the open-drain bus against the target.
`timescale 1ns/1ps
module tb_kei_i2c_slave_responder;
    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] slv_addr;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic       addressed, rd_mode, stop_det, rx_nack, tx_underflow;
    logic       m_scl_low = 1'b0;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_tbl [4];
    int         n_checks = 0, n_fail = 0;
    int         n_stop = 0, n_nack = 0, n_txrdy = 0, n_unf = 0;
    int         max_stretch = 0;

    always #5 clk = ~clk;

    kei_i2c_slave_responder_if bus();
    assign bus.scl_i = ~(m_scl_low | bus.scl_oe);
    assign bus.sda_i = ~(m_sda_low | bus.sda_oe);
    assign tx_data   = tx_tbl[n_txrdy[1:0]];

    kei_i2c_slave_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .slv_addr     (slv_addr),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .addressed    (addressed),
        .rd_mode      (rd_mode),
        .stop_det     (stop_det),
        .rx_nack      (rx_nack),
        .tx_underflow (tx_underflow)
    );

    always @(posedge clk) begin
        if (stop_det)     n_stop++;
        if (rx_nack)      n_nack++;
        if (tx_ready)     n_txrdy++;
        if (tx_underflow) n_unf++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic q_wait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic scl_release();
        int n = 0;
        m_scl_low = 1'b0;
        #1;
        while (bus.scl_i !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) check_val("scl_release_timeout", 32'(bus.scl_i), 1);
        if (n > max_stretch) max_stretch = n;
    endtask

    task automatic start_cond();
        m_sda_low = 1'b0; q_wait();
        scl_release();    q_wait();
        m_sda_low = 1'b1; q_wait();
        m_scl_low = 1'b1; q_wait();
    endtask

    task automatic stop_cond();
        m_sda_low = 1'b1; q_wait();
        scl_release();    q_wait();
        m_sda_low = 1'b0; q_wait();
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;   q_wait();
        scl_release();    q_wait(); q_wait();
        m_scl_low = 1'b1; q_wait();
    endtask

    task automatic recv_bit(output logic b);
        m_sda_low = 1'b0; q_wait();
        scl_release();    q_wait();
        b = bus.sda_i;    q_wait();
        m_scl_low = 1'b1; q_wait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(nack);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!rx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] wr_bytes [3];
        int         s_stop, s_nack, s_rdy, s_unf;

        rx_ready = 1'b0;
        tx_valid = 1'b0;
        slv_addr = 7'h55;
        for (int i = 0; i < 4; i++) tx_tbl[i] = 8'h00;
        wr_bytes[0] = 8'hAA; wr_bytes[1] = 8'h0F; wr_bytes[2] = 8'h3C;

        repeat (3) @(negedge clk);
        check_val("rst_sda_oe", bus.sda_oe, 0);
        check_val("rst_scl_oe", bus.scl_oe, 0);
        check_val("rst_rx_valid", rx_valid, 0);
        check_val("rst_rx_data", rx_data, 0);
        check_val("rst_addressed", addressed, 0);
        check_val("rst_rd_mode", rd_mode, 0);
        rst_n = 1'b1;
        q_wait();

        // Three-byte write to our address.
        s_stop = n_stop;
        start_cond();
        write_byte(8'hAA, ack);
        check_val("t1_addr_ack", ack, 1);
        check_val("t1_addressed", addressed, 1);
        check_val("t1_rd_mode", rd_mode, 0);
        for (int i = 0; i < 3; i++) begin
            write_byte(wr_bytes[i], ack);
            check_val("t1_data_ack", ack, 1);
        end
        stop_cond();
        check_val("t1_stop_pulses", n_stop - s_stop, 1);
        check_val("t1_addressed_after_stop", addressed, 0);
        for (int i = 0; i < 3; i++) pop_check("t1_pop", wr_bytes[i]);
        check_val("t1_fifo_empty", rx_valid, 0);

        // Six bytes into a 4-deep FIFO with no draining.
        s_nack = n_nack;
        start_cond();
        write_byte(8'hAA, ack);
        check_val("t2_addr_ack", ack, 1);
        for (int k = 0; k < 6; k++) begin
            write_byte(8'(8'h11 * (k + 1)), ack);
            check_val("t2_data_ack", ack, (k < 4) ? 1 : 0);
        end
        check_val("t2_rx_nack_pulses", n_nack - s_nack, 1);
        stop_cond();
        for (int k = 0; k < 4; k++) pop_check("t2_pop", 8'(8'h11 * (k + 1)));
        check_val("t2_fifo_empty", rx_valid, 0);

        // Reset in the middle of a data ACK.
        start_cond();
        write_byte(8'hAA, ack);
        write_byte(8'h5A, ack);
        check_val("t3_pre_ack", ack, 1);
        for (int i = 7; i >= 0; i--) send_bit(i[0]);
        m_sda_low = 1'b0; q_wait();
        scl_release();    q_wait();
        check_val("t3_sda_oe_before_rst", bus.sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check_val("t3_sda_oe_async", bus.sda_oe, 0);
        check_val("t3_fifo_empty", rx_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q_wait();
        start_cond();
        write_byte(8'hAA, ack);
        check_val("t3_post_addr_ack", ack, 1);
        write_byte(8'h99, ack);
        check_val("t3_post_data_ack", ack, 1);
        stop_cond();
        pop_check("t3_pop", 8'h99);

        // Two-byte read, master NACKs the second.
        tx_tbl[n_txrdy % 4]       = 8'h12;
        tx_tbl[(n_txrdy + 1) % 4] = 8'h34;
        tx_valid = 1'b1;
        s_rdy = n_txrdy;
        start_cond();
        write_byte(8'hAB, ack);
        check_val("t4_addr_ack", ack, 1);
        check_val("t4_rd_mode", rd_mode, 1);
        read_byte(d, 1'b0);
        check_val("t4_rd0", d, 8'h12);
        read_byte(d, 1'b1);
        check_val("t4_rd1", d, 8'h34);
        check_val("t4_sda_released", bus.sda_oe, 0);
        stop_cond();
        check_val("t4_tx_ready_pulses", n_txrdy - s_rdy, 2);
        tx_valid = 1'b0;

        // Read with no TX data available.
        s_rdy = n_txrdy;
        s_unf = n_unf;
        start_cond();
        write_byte(8'hAB, ack);
        check_val("t5_addr_ack", ack, 1);
`ifdef KEI_I2C_SLV_STRETCH_EN
        tx_tbl[n_txrdy % 4] = 8'h12;
        max_stretch = 0;
        fork
            begin
                repeat (200) @(negedge clk);
                tx_valid = 1'b1;
            end
        join_none
        read_byte(d, 1'b1);
        check_val("t5_stretched_byte", d, 8'h12);
        check_val("t5_stretch_long", 32'(max_stretch >= 150), 1);
        check_val("t5_scl_oe_released", bus.scl_oe, 0);
        check_val("t5_tx_ready_pulses", n_txrdy - s_rdy, 1);
`else
        read_byte(d, 1'b1);
        check_val("t5_underflow_byte", d, 8'hFF);
        check_val("t5_underflow_pulses", n_unf - s_unf, 1);
        check_val("t5_tx_ready_pulses", n_txrdy - s_rdy, 0);
        check_val("t5_scl_oe", bus.scl_oe, 0);
`endif
        stop_cond();
        tx_valid = 1'b0;

        // Wrong address, then repeated START to our address for a read.
        tx_tbl[n_txrdy % 4] = 8'h77;
        tx_valid = 1'b1;
        start_cond();
        write_byte(8'hAC, ack);
        check_val("t6_wrong_addr_ack", ack, 0);
        check_val("t6_wrong_addressed", addressed, 0);
        start_cond();
        write_byte(8'hAB, ack);
        check_val("t6_sr_addr_ack", ack, 1);
        check_val("t6_rd_mode", rd_mode, 1);
        check_val("t6_addressed", addressed, 1);
        read_byte(d, 1'b1);
        check_val("t6_rd", d, 8'h77);
        stop_cond();
        check_val("t6_addressed_after_stop", addressed, 0);
        tx_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
